// File: rtl/regfile_fwd_sb.sv
// regfile_fwd_sb: decode-stage register file with operand forwarding and a
// pending-write scoreboard.
//
// Read ports are combinational. Each port takes its operand from the first of these that applies:
//   1. the youngest matching forwarding tap;
//   2. the writeback bypass;
//   3. the stored register.
// A per-register pending bit tracks in-flight writers. From the pending bits and the
// forwarding taps the block raises a load-use stall. It also keeps an exception PC shadow
// register and a saturating count of stall cycles.
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_rd_sel, i_rd_used            per-port read selects / operand-consumed flags
//   o_rd_data                      per-port forwarded read data
//   i_wr_en, i_wr_sel, i_wr_data   writeback write
//   i_iss_en, i_iss_sel            issued instruction destination (marks pending)
//   i_fwd_valid/ready/sel/data     EX/MEM/WB forwarding taps, index 0 youngest
//   i_epc_save, i_epc_in, o_epc    exception PC capture
//   o_stall, o_stall_cnt, i_cnt_clr  stall request and saturating stall counter
//   o_err                          illegal select seen on an active port
module regfile_fwd_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_FWD  = 3,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_sel,
  input  logic [NUM_RD-1:0]          i_rd_used,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_sel,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_iss_en,
  input  logic [ADDR_W-1:0]          i_iss_sel,
  input  logic [NUM_FWD-1:0]         i_fwd_valid,
  input  logic [NUM_FWD-1:0]         i_fwd_ready,
  input  logic [NUM_FWD*ADDR_W-1:0]  i_fwd_sel,
  input  logic [NUM_FWD*DATA_W-1:0]  i_fwd_data,
  input  logic                       i_epc_save,
  input  logic [DATA_W-1:0]          i_epc_in,
  output logic [DATA_W-1:0]          o_epc,
  output logic                       o_stall,
  output logic [CNT_W-1:0]           o_stall_cnt,
  input  logic                       i_cnt_clr,
  output logic                       o_err
);

  // Storage spans the full select space so out-of-range selects index a slot that is never
  // written and therefore always reads 0 and is never pending.
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pending;
  logic [DATA_W-1:0] r_epc;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [NUM_RD-1:0] w_port_stall;
  logic              w_rd_err;
  logic              w_wr_ok;
  logic              w_iss_ok;
  logic [ADDR_W-1:0] w_sel;
  logic              w_hit;
  logic              w_tap_rdy;
  logic [DATA_W-1:0] w_tap_data;
  logic              w_byp;

  function automatic logic f_valid(input logic [ADDR_W-1:0] sel);
    f_valid = (int'(sel) < int'(NUM_REGS));
  endfunction

  function automatic logic f_zero(input logic [ADDR_W-1:0] sel);
    f_zero = (ZERO_REG != 0) && (sel == '0);
  endfunction

  // Read path, stall terms and read-select errors
  always_comb begin
    o_rd_data    = '0;
    w_port_stall = '0;
    w_rd_err     = 1'b0;
    w_sel        = '0;
    w_hit        = 1'b0;
    w_tap_rdy    = 1'b1;
    w_tap_data   = '0;
    w_byp        = 1'b0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      w_sel      = i_rd_sel[k*ADDR_W +: ADDR_W];
      w_hit      = 1'b0;
      w_tap_rdy  = 1'b1;
      w_tap_data = '0;
      // Walk oldest to youngest so the lowest-index match is the one left standing.
      for (int j = int'(NUM_FWD) - 1; j >= 0; j--) begin
        if (i_fwd_valid[j] && (i_fwd_sel[j*ADDR_W +: ADDR_W] == w_sel)) begin
          w_hit      = 1'b1;
          w_tap_rdy  = i_fwd_ready[j];
          w_tap_data = i_fwd_data[j*DATA_W +: DATA_W];
        end
      end
      w_byp = i_wr_en && (i_wr_sel == w_sel);

      if (f_zero(w_sel)) begin
        o_rd_data[k*DATA_W +: DATA_W] = '0;
      end else if (w_hit) begin
        o_rd_data[k*DATA_W +: DATA_W] = w_tap_data;
      end else if (w_byp) begin
        o_rd_data[k*DATA_W +: DATA_W] = i_wr_data;
      end else begin
        o_rd_data[k*DATA_W +: DATA_W] = r_regs[w_sel];
      end

      // An unmatched pending register is fine if its writeback lands this very cycle.
      if (i_rd_used[k] && !f_zero(w_sel)) begin
        w_port_stall[k] = w_hit ? !w_tap_rdy : (r_pending[w_sel] && !w_byp);
      end
      if (i_rd_used[k] && !f_valid(w_sel)) begin
        w_rd_err = 1'b1;
      end
    end
  end

  assign o_stall  = |w_port_stall;
  assign w_wr_ok  = i_wr_en && f_valid(i_wr_sel) && !f_zero(i_wr_sel);
  // A stalled instruction is held upstream, so its issue must not mark anything yet.
  assign w_iss_ok = i_iss_en && !o_stall && f_valid(i_iss_sel) && !f_zero(i_iss_sel);
  assign o_err    = w_rd_err || (i_wr_en && !f_valid(i_wr_sel)) ||
                    (i_iss_en && !f_valid(i_iss_sel));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[i_wr_sel] <= i_wr_data;
    end
  end

  // Scoreboard: a same-cycle set beats the clear because the issued writer is newer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_iss_ok && (int'(i_iss_sel) == i)) begin
          r_pending[i] <= 1'b1;
        end else if (w_wr_ok && (int'(i_wr_sel) == i)) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_epc <= '0;
    end else if (i_epc_save) begin
      r_epc <= i_epc_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (o_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_epc       = r_epc;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Self-checking bench for regfile_fwd_sb: directed scenarios followed by
// randomized traffic checked against a behavioural model of the register file.
module tb_regfile_fwd_sb;

  localparam int DW  = 16;
  localparam int NR  = 6;
  localparam int AW  = 3;
  localparam int NRD = 2;
  localparam int NF  = 3;
  localparam int CW  = 4;

  logic              clk;
  logic              rst_n;
  logic [NRD*AW-1:0] rd_sel;
  logic [NRD-1:0]    rd_used;
  logic [NRD*DW-1:0] rd_data;
  logic              wr_en;
  logic [AW-1:0]     wr_sel;
  logic [DW-1:0]     wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_sel;
  logic [NF-1:0]     fwd_valid;
  logic [NF-1:0]     fwd_ready;
  logic [NF*AW-1:0]  fwd_sel;
  logic [NF*DW-1:0]  fwd_data;
  logic              epc_save;
  logic [DW-1:0]     epc_in;
  logic [DW-1:0]     epc;
  logic              stall;
  logic [CW-1:0]     stall_cnt;
  logic              cnt_clr;
  logic              err;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model state
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];
  logic [DW-1:0] m_epc;
  int            m_cnt;

  regfile_fwd_sb #(
    .DATA_W  (DW),
    .NUM_REGS(NR),
    .NUM_RD  (NRD),
    .NUM_FWD (NF),
    .ZERO_REG(1),
    .CNT_W   (CW)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rd_sel   (rd_sel),
    .i_rd_used  (rd_used),
    .o_rd_data  (rd_data),
    .i_wr_en    (wr_en),
    .i_wr_sel   (wr_sel),
    .i_wr_data  (wr_data),
    .i_iss_en   (iss_en),
    .i_iss_sel  (iss_sel),
    .i_fwd_valid(fwd_valid),
    .i_fwd_ready(fwd_ready),
    .i_fwd_sel  (fwd_sel),
    .i_fwd_data (fwd_data),
    .i_epc_save (epc_save),
    .i_epc_in   (epc_in),
    .o_epc      (epc),
    .o_stall    (stall),
    .o_stall_cnt(stall_cnt),
    .i_cnt_clr  (cnt_clr),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_sel = '0; rd_used = '0; wr_en = 0; wr_sel = '0; wr_data = '0;
    iss_en = 0; iss_sel = '0; fwd_valid = '0; fwd_ready = '1; fwd_sel = '0;
    fwd_data = '0; epc_save = 0; epc_in = '0; cnt_clr = 0;
  endtask

  task automatic set_rd(input int k, input int sel);
    rd_sel[k*AW +: AW] = AW'(sel);
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  // ---------------- reference model ----------------
  function automatic int psel(input int k);
    return int'(rd_sel[k*AW +: AW]);
  endfunction

  // First tap (youngest first) holding this register, or -1.
  function automatic int m_tap(input int sel);
    for (int j = 0; j < NF; j++)
      if (fwd_valid[j] && int'(fwd_sel[j*AW +: AW]) == sel) return j;
    return -1;
  endfunction

  function automatic logic [DW-1:0] m_data(input int k);
    int sel = psel(k);
    int j = m_tap(sel);
    if (sel == 0) return '0;
    if (j >= 0) return fwd_data[j*DW +: DW];
    if (wr_en && int'(wr_sel) == sel) return wr_data;
    if (sel < NR) return m_regs[sel];
    return '0;
  endfunction

  function automatic bit m_stall();
    for (int k = 0; k < NRD; k++) begin
      int sel = psel(k);
      int j = m_tap(sel);
      if (rd_used[k] && sel != 0) begin
        if (j >= 0) begin
          if (!fwd_ready[j]) return 1;
        end else if (sel < NR && m_pend[sel] && !(wr_en && int'(wr_sel) == sel)) begin
          return 1;
        end
      end
    end
    return 0;
  endfunction

  function automatic bit m_err();
    for (int k = 0; k < NRD; k++) if (rd_used[k] && psel(k) >= NR) return 1;
    if (wr_en && int'(wr_sel) >= NR) return 1;
    if (iss_en && int'(iss_sel) >= NR) return 1;
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
    m_epc = '0;
    m_cnt = 0;
  endtask

  task automatic m_edge(input bit st);
    int ws = int'(wr_sel);
    int is = int'(iss_sel);
    if (wr_en && ws < NR && ws != 0) begin
      m_regs[ws] = wr_data;
      m_pend[ws] = 0;
    end
    if (iss_en && !st && is < NR && is != 0) m_pend[is] = 1;
    if (epc_save) m_epc = epc_in;
    if (cnt_clr) m_cnt = 0;
    else if (st && m_cnt < (1 << CW) - 1) m_cnt++;
  endtask

  function automatic int rnd_sel();
    if ($urandom_range(0, 15) == 0) return NR + int'($urandom_range(0, 1));
    return int'($urandom_range(0, NR - 1));
  endfunction

  initial begin
    bit st;
    idle();
    rst_n = 0;
    #3;
    check("rst_rd0", 32'(rd(0)), 0);
    check("rst_epc", 32'(epc), 0);
    check("rst_cnt", 32'(stall_cnt), 0);
    check("rst_stall", 32'(stall), 0);
    #19 rst_n = 1;
    tick();

    // write and same-cycle bypass, then readback
    set_rd(1, 3); wr_en = 1; wr_sel = 3; wr_data = 16'hBEEF;
    #1 check("bypass", 32'(rd(1)), 32'hBEEF);
    tick();
    wr_en = 0; set_rd(0, 3);
    #1 check("readback", 32'(rd(0)), 32'hBEEF);

    // forwarding priority
    set_rd(0, 5);
    fwd_valid = 3'b111; fwd_ready = 3'b111; fwd_sel = {3'd5, 3'd5, 3'd5};
    fwd_data = {16'h3333, 16'h2222, 16'h1111};
    #1 check("fwd_tap0", 32'(rd(0)), 32'h1111);
    fwd_valid = 3'b110;
    #1 check("fwd_tap1", 32'(rd(0)), 32'h2222);
    fwd_valid = '0;

    // load-use
    iss_en = 1; iss_sel = 2;
    tick();
    iss_en = 0;
    fwd_valid = 3'b001; fwd_ready = 3'b110; fwd_sel = {3'd0, 3'd0, 3'd2};
    fwd_data = {16'h0, 16'h0, 16'hABCD};
    rd_used = 2'b01; set_rd(0, 2);
    #1 check("lu_stall", 32'(stall), 1);
    check("lu_cnt0", 32'(stall_cnt), 0);
    tick();
    check("lu_cnt1", 32'(stall_cnt), 1);
    fwd_ready = 3'b111;
    #1 check("lu_release", 32'(stall), 0);
    check("lu_data", 32'(rd(0)), 32'hABCD);
    tick();
    check("lu_cnt_hold", 32'(stall_cnt), 1);
    fwd_valid = '0; rd_used = '0;
    wr_en = 1; wr_sel = 2; wr_data = 16'h2222;
    tick();

    // scoreboard race: set wins
    iss_en = 1; iss_sel = 4; wr_en = 1; wr_sel = 4; wr_data = 16'h4444;
    tick();
    iss_en = 0; wr_en = 0; rd_used = 2'b01; set_rd(0, 4);
    #1 check("race_pend", 32'(stall), 1);
    check("race_data", 32'(rd(0)), 32'h4444);
    for (int i = 0; i < 5; i++) tick();
    check("cnt_mid", 32'(stall_cnt), 6);
    for (int i = 0; i < 15; i++) tick();
    check("cnt_sat", 32'(stall_cnt), 15);
    check("stall_held", 32'(stall), 1);
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    check("cnt_clr", 32'(stall_cnt), 0);
    wr_en = 1; wr_sel = 4; wr_data = 16'h5555;
    #1 check("wr_unstall", 32'(stall), 0);
    check("wr_byp4", 32'(rd(0)), 32'h5555);
    tick();
    wr_en = 0;
    #1 check("pend_clr", 32'(stall), 0);
    check("cnt_idle", 32'(stall_cnt), 0);

    // zero register
    wr_en = 1; wr_sel = 0; wr_data = 16'h0007; iss_en = 1; iss_sel = 0; set_rd(0, 0);
    #1 check("zero_byp", 32'(rd(0)), 0);
    tick();
    wr_en = 0; iss_en = 0;
    #1 check("zero_rd", 32'(rd(0)), 0);
    check("zero_stall", 32'(stall), 0);

    // illegal selects
    rd_used = 2'b10; set_rd(1, 7);
    #1 check("err_rd", 32'(err), 1);
    rd_used = 2'b00;
    #1 check("err_rd_unused", 32'(err), 0);
    wr_en = 1; wr_sel = 6; wr_data = 16'h6666;
    #1 check("err_wr", 32'(err), 1);
    tick();
    wr_en = 0; iss_en = 1; iss_sel = 7;
    #1 check("err_iss", 32'(err), 1);
    iss_en = 0;

    // epc and asynchronous reset
    epc_save = 1; epc_in = 16'h1234;
    tick();
    epc_save = 0;
    check("epc", 32'(epc), 32'h1234);
    fwd_valid = 3'b001; fwd_ready = 3'b110; fwd_sel = {3'd0, 3'd0, 3'd3};
    rd_used = 2'b01; set_rd(0, 3);
    tick();
    check("cnt_pre_rst", 32'(stall_cnt), 1);
    #2 rst_n = 0;
    #1 check("arst_epc", 32'(epc), 0);
    check("arst_cnt", 32'(stall_cnt), 0);
    idle(); set_rd(0, 3);
    #1 check("arst_reg", 32'(rd(0)), 0);
    rst_n = 1;
    m_reset();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NRD; k++) begin
        set_rd(k, rnd_sel());
        rd_used[k] = 1'($urandom_range(0, 1));
      end
      wr_en = ($urandom_range(0, 2) == 0); wr_sel = AW'(rnd_sel()); wr_data = DW'($urandom);
      iss_en = ($urandom_range(0, 2) == 0); iss_sel = AW'(rnd_sel());
      for (int j = 0; j < NF; j++) begin
        fwd_valid[j] = 1'($urandom_range(0, 1));
        fwd_ready[j] = ($urandom_range(0, 4) != 0);
        fwd_sel[j*AW +: AW] = AW'($urandom_range(0, NR - 1));
        fwd_data[j*DW +: DW] = DW'($urandom);
      end
      epc_save = ($urandom_range(0, 7) == 0); epc_in = DW'($urandom);
      cnt_clr = ($urandom_range(0, 31) == 0);
      #1;
      st = m_stall();
      check("r_rd0", 32'(rd(0)), 32'(m_data(0)));
      check("r_rd1", 32'(rd(1)), 32'(m_data(1)));
      check("r_stall", 32'(stall), 32'(st));
      check("r_err", 32'(err), 32'(m_err()));
      check("r_epc", 32'(epc), 32'(m_epc));
      check("r_cnt", 32'(stall_cnt), 32'(m_cnt));
      @(posedge clk);
      m_edge(st);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
